serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter WIDTH, default 8, payload word width in bits; legal range 2..32.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 tx_enable  input  1  global clock enable; when low, all internal state SHALL hold.
REQ-005 in_valid  input  1  producer has a word on in_data.
REQ-006 in_data  input  WIDTH  parallel word to transmit.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 ser_d  output  1  serial data bit, MSB first.
REQ-009 ser_en  output  1  bit strobe; receiver flip-flops capture ser_d only when ser_en=1.
REQ-010 ser_last  output  1  high with the final (LSB) bit of each word.
REQ-011 busy  output  1  high while a word is in flight.

Function
REQ-012 States: IDLE, SHIFT; all outputs except in_ready SHALL be registered.
REQ-013 Transfer SHALL occur on a rising edge where in_valid=1, in_ready=1 and tx_enable=1.
REQ-014 in_ready SHALL be combinational: (state==IDLE or (state==SHIFT and bit_cnt==WIDTH-1)) and tx_enable.
REQ-015 IDLE + transfer -> SHIFT; in_data loaded into shift register, bit_cnt=0, ser_d=in_data[WIDTH-1], ser_en=1.
REQ-016 Latency: word accepted at edge k SHALL present its MSB from edge k until edge k+1, LSB from edge k+WIDTH-1, with tx_enable held high.
REQ-017 SHIFT, tx_enable=1, bit_cnt<WIDTH-1: shift left, bit_cnt+1, ser_d=next bit, ser_en=1.
REQ-018 ser_last SHALL be 1 exactly while bit_cnt==WIDTH-1 in SHIFT.
REQ-019 SHIFT, bit_cnt==WIDTH-1, no transfer: -> IDLE, ser_en=0, ser_d=0, ser_last=0, busy=0.
REQ-020 SHIFT, bit_cnt==WIDTH-1, transfer: reload, stay SHIFT; back-to-back words SHALL have zero gap cycles.
REQ-021 tx_enable=0: state, shift register, bit_cnt, ser_d, ser_last, busy SHALL hold; ser_en SHALL be forced 0 (combinational gate on registered strobe).
REQ-022 in_data SHALL be ignored when no transfer occurs; changes to in_data mid-word SHALL not affect ser_d.
REQ-023 busy SHALL equal (state==SHIFT).

Reset
REQ-024 reset=1 at a rising edge SHALL force IDLE, bit_cnt=0, shift register=0, ser_d=0, ser_en=0, ser_last=0, busy=0, regardless of tx_enable.
REQ-025 Reset mid-word SHALL abort the word; no further bits of it SHALL be emitted; reset has priority over a simultaneous transfer.
REQ-026 in_ready SHALL be 0 while reset=1.

Structure
REQ-027 Shared package serial_pkg SHALL hold the state enum (IDLE, SHIFT) and the default WIDTH constant.
REQ-028 bit_cnt width SHALL be $clog2(WIDTH) bits.
REQ-029 One sub-module, serial_bit_counter (clear, enable, terminal-count flag), SHALL be instantiated; all other logic lives in serial_tx.

Verification
REQ-030 Reset then in_data=8'hA5, in_valid=1 one cycle -> ser_d 1,0,1,0,0,1,0,1 on 8 consecutive cycles, ser_en=1 each, ser_last only on 8th, then busy=0.
REQ-031 Back-to-back 8'hFF then 8'h00, in_valid held -> 16 contiguous ser_en cycles, ser_d eight 1s then eight 0s, ser_last on cycles 8 and 16.
REQ-032 Send 8'hC3, drop tx_enable for 3 cycles after bit 2 -> ser_en=0 and ser_d frozen at 0 for those cycles, stream resumes 0,0,0,0,1,1 without loss.
REQ-033 Send 8'h81, assert reset during bit 4 -> next cycle all outputs 0, in_ready=1 after reset release, no residual bits.
REQ-034 in_valid=1 with tx_enable=0 in IDLE -> no transfer, busy stays 0; change in_data during a word -> serialized bits unchanged.
REQ-035 Bench SHALL check each bit with a self-checking deserializer model capturing ser_d on ser_en, comparing reconstructed words.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter: FSM state encoding and default word width.
package serial_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

endpackage

// File: rtl/serial_bit_counter.sv
// Bit position counter for the serializer; tc_c flags the final (LSB) position of a word.
module serial_bit_counter
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     enable,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     tc_c
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Clear wins over enable so a reload always restarts at the MSB position.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign tc_c = (count == LAST);

endmodule

// File: rtl/serial_tx.sv
// MSB-first parallel-to-serial transmitter with valid/ready intake, global clock enable and bit strobe.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_enable,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_d,
    output logic             ser_en,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    tx_state_e        state;
    tx_state_e        state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             strobe;
    logic             strobe_next;
    logic             last_reg;
    logic             last_next;
    logic             busy_reg;
    logic             busy_next;

    logic [CW-1:0]    bit_cnt;
    logic             cnt_tc;
    logic             transfer;
    logic             advance;
    logic             finish;

    // Ready in IDLE or on the final bit so consecutive words stream with no gap.
    assign in_ready = tx_enable && !reset
                      && ((state == IDLE) || ((state == SHIFT) && cnt_tc));
    assign transfer = in_valid && in_ready;
    assign advance  = tx_enable && (state == SHIFT) && !cnt_tc;
    assign finish   = tx_enable && (state == SHIFT) && cnt_tc && !transfer;

    serial_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (transfer || finish),
        .enable (advance),
        .count  (bit_cnt),
        .tc_c   (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            strobe    <= 1'b0;
            last_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            strobe    <= strobe_next;
            last_reg  <= last_next;
            busy_reg  <= busy_next;
        end
    end

    // Next-state and registered-output logic; with tx_enable low no branch fires and everything holds.
    always_comb begin
        state_next  = state;
        shift_next  = shift_reg;
        strobe_next = strobe;
        last_next   = last_reg;
        busy_next   = busy_reg;

        if (transfer) begin
            state_next  = SHIFT;
            shift_next  = in_data;
            strobe_next = 1'b1;
            last_next   = 1'b0;
            busy_next   = 1'b1;
        end else if (advance) begin
            shift_next  = {shift_reg[WIDTH-2:0], 1'b0};
            strobe_next = 1'b1;
            last_next   = (bit_cnt == PENULT);
        end else if (finish) begin
            state_next  = IDLE;
            shift_next  = '0;
            strobe_next = 1'b0;
            last_next   = 1'b0;
            busy_next   = 1'b0;
        end
    end

    // The current bit always sits in the shift register MSB; the strobe is gated by the enable.
    assign ser_d    = shift_reg[WIDTH-1];
    assign ser_en   = strobe && tx_enable;
    assign ser_last = last_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_serial_tx.sv
// Directed-vector bench for serial_tx with a deserializer scoreboard comparing reconstructed words.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_enable;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       ser_d;
    logic       ser_en;
    logic       ser_last;
    logic       busy;

    int         tests = 0;
    int         fails = 0;
    int         step_no = 0;
    int         words_seen = 0;
    logic [7:0] exp_q[$];

    serial_tx #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_enable (tx_enable),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ser_d     (ser_d),
        .ser_en    (ser_en),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs just after the rising edge, check outputs at the falling edge.
    task automatic step(input logic r, input logic en, input logic v, input logic [7:0] d,
                        input logic xd, input logic xen, input logic xlast,
                        input logic xbusy, input logic xrdy);
        @(posedge clk);
        #1;
        reset     = r;
        tx_enable = en;
        in_valid  = v;
        in_data   = d;
        @(negedge clk);
        step_no++;
        check($sformatf("s%0d ser_d", step_no), 32'(ser_d), 32'(xd));
        check($sformatf("s%0d ser_en", step_no), 32'(ser_en), 32'(xen));
        check($sformatf("s%0d ser_last", step_no), 32'(ser_last), 32'(xlast));
        check($sformatf("s%0d busy", step_no), 32'(busy), 32'(xbusy));
        check($sformatf("s%0d in_ready", step_no), 32'(in_ready), 32'(xrdy));
        if (v && xrdy) exp_q.push_back(d);
        if (r) exp_q.delete();
    endtask

    // Deserializer monitor: capture ser_d on ser_en, compare each word at ser_last.
    initial begin : monitor
        logic [7:0] acc;
        int         nbits;
        acc   = '0;
        nbits = 0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                acc   = '0;
                nbits = 0;
            end else if (ser_en === 1'b1) begin
                acc = {acc[6:0], ser_d};
                nbits++;
                if (ser_last === 1'b1) begin
                    check("deser word length", 32'(nbits), 32'd8);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL deser word: got %0h, expected no word", acc);
                    end else begin
                        check("deser word", 32'(acc), 32'(exp_q.pop_front()));
                    end
                    words_seen++;
                    nbits = 0;
                end else if (nbits >= 8) begin
                    tests++;
                    fails++;
                    $display("FAIL deser ser_last: got 0 after %0d bits, expected 1", nbits);
                    nbits = 0;
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        tx_enable = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        repeat (3) @(posedge clk);

        // reset state
        step(1, 1, 0, 8'h00, 0, 0, 0, 0, 0);

        // A5 with in_data churning (valid high, not ready) during the word
        step(0, 1, 1, 8'hA5, 0, 0, 0, 0, 1);
        step(0, 1, 1, 8'h00, 1, 1, 0, 1, 0);
        step(0, 1, 1, 8'hFF, 0, 1, 0, 1, 0);
        step(0, 1, 1, 8'h5A, 1, 1, 0, 1, 0);
        step(0, 1, 1, 8'h0F, 0, 1, 0, 1, 0);
        step(0, 1, 1, 8'hF0, 0, 1, 0, 1, 0);
        step(0, 1, 1, 8'h33, 1, 1, 0, 1, 0);
        step(0, 1, 1, 8'hCC, 0, 1, 0, 1, 0);
        step(0, 1, 0, 8'h00, 1, 1, 1, 1, 1);
        step(0, 1, 0, 8'h00, 0, 0, 0, 0, 1);

        // valid while disabled in IDLE: no transfer
        step(0, 0, 1, 8'h77, 0, 0, 0, 0, 0);
        step(0, 0, 1, 8'h77, 0, 0, 0, 0, 0);
        step(0, 1, 0, 8'h77, 0, 0, 0, 0, 1);

        // back-to-back FF then 00, 16 contiguous strobes
        step(0, 1, 1, 8'hFF, 0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(0, 1, 1, 8'h00, 1, 1, 0, 1, 0);
        step(0, 1, 1, 8'h00, 1, 1, 1, 1, 1);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 8'h00, 0, 1, 0, 1, 0);
        step(0, 1, 0, 8'h00, 0, 1, 1, 1, 1);
        step(0, 1, 0, 8'h00, 0, 0, 0, 0, 1);

        // C3 with a 3-cycle enable drop while bit 3 (a 0) is presented
        step(0, 1, 1, 8'hC3, 0, 0, 0, 0, 1);
        step(0, 1, 0, 8'h00, 1, 1, 0, 1, 0);
        step(0, 1, 0, 8'h00, 1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00, 0, 1, 0, 1, 0);
        step(0, 1, 0, 8'h00, 1, 1, 0, 1, 0);
        step(0, 1, 0, 8'h00, 1, 1, 1, 1, 1);
        step(0, 1, 0, 8'h00, 0, 0, 0, 0, 1);

        // 81 aborted by reset during bit 4; reset also while disabled with valid high
        step(0, 1, 1, 8'h81, 0, 0, 0, 0, 1);
        step(0, 1, 0, 8'h00, 1, 1, 0, 1, 0);
        step(0, 1, 0, 8'h00, 0, 1, 0, 1, 0);
        step(0, 1, 0, 8'h00, 0, 1, 0, 1, 0);
        step(1, 1, 0, 8'h00, 0, 1, 0, 1, 0);
        step(1, 0, 1, 8'h81, 0, 0, 0, 0, 0);
        step(0, 1, 0, 8'h00, 0, 0, 0, 0, 1);
        step(0, 1, 0, 8'h00, 0, 0, 0, 0, 1);

        // recovery word 5A
        step(0, 1, 1, 8'h5A, 0, 0, 0, 0, 1);
        step(0, 1, 0, 8'h00, 0, 1, 0, 1, 0);
        step(0, 1, 0, 8'h00, 1, 1, 0, 1, 0);
        step(0, 1, 0, 8'h00, 0, 1, 0, 1, 0);
        step(0, 1, 0, 8'h00, 1, 1, 0, 1, 0);
        step(0, 1, 0, 8'h00, 1, 1, 0, 1, 0);
        step(0, 1, 0, 8'h00, 0, 1, 0, 1, 0);
        step(0, 1, 0, 8'h00, 1, 1, 0, 1, 0);
        step(0, 1, 0, 8'h00, 0, 1, 1, 1, 1);
        step(0, 1, 0, 8'h00, 0, 0, 0, 0, 1);

        @(negedge clk);
        check("words delivered", 32'(words_seen), 32'd5);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
